// File: rtl/feistel_iter_core.sv
// feistel_iter_core: iterative Feistel block cipher, one round per clock.
// Key-expanded P/S tables live in registers; encrypt/decrypt chosen per block.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   key, key_valid/ready  key load handshake (K0 = low half, K1 = high half)
//   in_data, in_decrypt   block and direction, in_valid/in_ready handshake
//   out_data, out_valid   result, out_ready accepts it
//   busy                  high during key expansion or rounds
//   key_clear             only when FEISTEL_KEY_CLEAR_EN is defined:
//                         wipes tables and key (deferred while a block runs)
module feistel_iter_core #(
    parameter int HALF_W = 8,
    parameter int ROUNDS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [2*HALF_W-1:0] key,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [2*HALF_W-1:0] in_data,
    input  logic                in_decrypt,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*HALF_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
`ifdef FEISTEL_KEY_CLEAR_EN
    ,
    input  logic                key_clear
`endif
);

    localparam int BW  = 2 * HALF_W;
    localparam int NSB = HALF_W / 2;
    localparam int NE  = ROUNDS + 2 * HALF_W;
    localparam int EW  = $clog2(NE);
    localparam int RW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [31:0] GOLD = 32'h9E3779B9;
    localparam logic [HALF_W-1:0] GOLD_H = GOLD[HALF_W-1:0];

    typedef enum logic [2:0] {
        NOKEY,
        KEYEXP,
        READY,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // tab[0..ROUNDS-1] = P, tab[ROUNDS + 4*j + v] = S[j][v]
    logic [HALF_W-1:0] tab [NE];

    logic [BW-1:0]     key_q;
    logic [EW-1:0]     exp_cnt;
    logic [HALF_W-1:0] acc_q;
    logic [HALF_W-1:0] cst_q;
    logic [HALF_W-1:0] acc_d;
    logic [HALF_W-1:0] k_sel;

    logic [RW-1:0]     rnd_q;
    logic              dec_q;
    logic [HALF_W-1:0] l_q;
    logic [HALF_W-1:0] r_q;
    logic [HALF_W-1:0] l_d;
    logic [HALF_W-1:0] r_d;
    logic [HALF_W-1:0] f_in;
    logic [HALF_W-1:0] f_out;
    logic [HALF_W-1:0] p_sel;

    logic last_rnd;
    logic exp_last;
    logic key_hs;
    logic blk_hs;
    logic clr_now;

`ifdef FEISTEL_KEY_CLEAR_EN
    logic clr_pend;

    // A clear seen mid-block waits until the result has been taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_pend <= 1'b0;
        end else if (clr_now) begin
            clr_pend <= 1'b0;
        end else if (key_clear && state_q == RUN) begin
            clr_pend <= 1'b1;
        end
    end

    assign clr_now = (key_clear && state_q != RUN)
                   || (clr_pend && state_q == DONE && out_ready);
`else
    assign clr_now = 1'b0;
`endif

    assign exp_last = (exp_cnt == EW'(NE - 1));
    assign last_rnd = dec_q ? (rnd_q == '0)
                            : (rnd_q == RW'(ROUNDS - 1));

    assign key_hs = key_valid && !clr_now
                  && (state_q == NOKEY || state_q == READY);
    // A key request in READY takes priority over an offered block.
    assign blk_hs = in_valid && !key_valid && !clr_now
                  && state_q == READY;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NOKEY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) state_d = KEYEXP;
            end
            KEYEXP: begin
                busy = 1'b1;
                if (exp_last) state_d = READY;
            end
            READY: begin
                key_ready = 1'b1;
                in_ready  = 1'b1;
                if (key_valid) begin
                    state_d = KEYEXP;
                end else if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_rnd) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = READY;
            end
            default: state_d = NOKEY;
        endcase
        if (clr_now) state_d = NOKEY;
    end

    // Entry i mixes the i-th golden-ratio multiple, the alternating key
    // half and the previous entry; the multiple is kept as a running sum.
    always_comb begin
        k_sel = exp_cnt[0] ? key_q[BW-1:HALF_W] : key_q[HALF_W-1:0];
        acc_d = cst_q ^ k_sel ^ acc_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= '0;
            exp_cnt <= '0;
            acc_q   <= '0;
            cst_q   <= '0;
        end else if (clr_now) begin
            key_q   <= '0;
        end else if (key_hs) begin
            key_q   <= key;
            exp_cnt <= '0;
            acc_q   <= '0;
            cst_q   <= GOLD_H;
        end else if (state_q == KEYEXP) begin
            exp_cnt <= exp_cnt + EW'(1);
            acc_q   <= acc_d;
            cst_q   <= cst_q + GOLD_H;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NE; i++) tab[i] <= '0;
        end else if (clr_now) begin
            for (int i = 0; i < NE; i++) tab[i] <= '0;
        end else if (state_q == KEYEXP) begin
            for (int i = 0; i < NE; i++) begin
                if (exp_cnt == EW'(i)) tab[i] <= acc_d;
            end
        end
    end

    always_comb begin
        p_sel = '0;
        for (int r = 0; r < ROUNDS; r++) begin
            if (rnd_q == RW'(r)) p_sel = tab[r];
        end
    end

    // F: each 2-bit slice of the input selects one entry of its S-box.
    always_comb begin
        f_in  = dec_q ? r_q : l_q;
        f_out = '0;
        for (int j = 0; j < NSB; j++) begin
            for (int v = 0; v < 4; v++) begin
                if (f_in[2*j +: 2] == 2'(v)) begin
                    f_out = f_out ^ tab[ROUNDS + 4*j + v];
                end
            end
        end
    end

    always_comb begin
        if (dec_q) begin
            l_d = r_q;
            r_d = l_q ^ f_out ^ p_sel;
        end else begin
            l_d = r_q ^ f_out ^ p_sel;
            r_d = l_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            l_q      <= '0;
            r_q      <= '0;
            rnd_q    <= '0;
            dec_q    <= 1'b0;
            out_data <= '0;
        end else if (blk_hs) begin
            l_q   <= in_data[BW-1:HALF_W];
            r_q   <= in_data[HALF_W-1:0];
            dec_q <= in_decrypt;
            rnd_q <= in_decrypt ? RW'(ROUNDS - 1) : '0;
        end else if (state_q == RUN) begin
            l_q <= l_d;
            r_q <= r_d;
            rnd_q <= dec_q ? rnd_q - RW'(1) : rnd_q + RW'(1);
            if (last_rnd) out_data <= {l_d, r_d};
        end
    end

endmodule

// File: tb/tb_feistel_iter_core.sv
// tb_feistel_iter_core: three cipher configurations checked against
// a behavioural model of the key schedule and Feistel rounds.
module tb_feistel_iter_core;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic [31:0] key_s [3];
    logic [31:0] din [3];
    logic [2:0]  kv;
    logic [2:0]  dec_s;
    logic [2:0]  iv;
    logic [2:0]  orr;
    logic [2:0]  key_rdy;
    logic [2:0]  in_rdy;
    logic [2:0]  out_v;
    logic [2:0]  busy;
    logic [15:0] od0;
    logic [7:0]  od1;
    logic [31:0] od2;
    logic [31:0] od [3];

    assign od[0] = {16'b0, od0};
    assign od[1] = {24'b0, od1};
    assign od[2] = od2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int krbad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    feistel_iter_core #(.HALF_W(8), .ROUNDS(8)) u0 (
        .clock(clock), .reset_n(reset_n),
        .key(key_s[0][15:0]), .key_valid(kv[0]), .key_ready(key_rdy[0]),
        .in_data(din[0][15:0]), .in_decrypt(dec_s[0]),
        .in_valid(iv[0]), .in_ready(in_rdy[0]),
        .out_data(od0), .out_valid(out_v[0]), .out_ready(orr[0]),
        .busy(busy[0])
`ifdef FEISTEL_KEY_CLEAR_EN
        , .key_clear(1'b0)
`endif
    );

    feistel_iter_core #(.HALF_W(4), .ROUNDS(1)) u1 (
        .clock(clock), .reset_n(reset_n),
        .key(key_s[1][7:0]), .key_valid(kv[1]), .key_ready(key_rdy[1]),
        .in_data(din[1][7:0]), .in_decrypt(dec_s[1]),
        .in_valid(iv[1]), .in_ready(in_rdy[1]),
        .out_data(od1), .out_valid(out_v[1]), .out_ready(orr[1]),
        .busy(busy[1])
`ifdef FEISTEL_KEY_CLEAR_EN
        , .key_clear(1'b0)
`endif
    );

    feistel_iter_core #(.HALF_W(16), .ROUNDS(32)) u2 (
        .clock(clock), .reset_n(reset_n),
        .key(key_s[2]), .key_valid(kv[2]), .key_ready(key_rdy[2]),
        .in_data(din[2]), .in_decrypt(dec_s[2]),
        .in_valid(iv[2]), .in_ready(in_rdy[2]),
        .out_data(od2), .out_valid(out_v[2]), .out_ready(orr[2]),
        .busy(busy[2])
`ifdef FEISTEL_KEY_CLEAR_EN
        , .key_clear(1'b0)
`endif
    );

    function automatic int hw_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 4 : 16;
    endfunction

    function automatic int rn_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 1 : 32;
    endfunction

    function automatic logic [31:0] bw_mask(input int d);
        logic [63:0] m;
        m = (64'h1 << (2 * hw_of(d))) - 64'h1;
        return m[31:0];
    endfunction

    // Key schedule and cipher straight from the algorithm description.
    function automatic logic [31:0] model(input int hw, input int rn,
                                          input logic [31:0] k,
                                          input logic [31:0] blk,
                                          input bit dec);
        logic [31:0] m, k0, k1, acc, c, l, r, t, f, x;
        logic [31:0] p [32];
        logic [31:0] s [8][4];
        int ne, rr;
        m   = (32'h1 << hw) - 32'h1;
        k0  = k & m;
        k1  = (k >> hw) & m;
        ne  = rn + 2 * hw;
        acc = 0;
        for (int i = 0; i < ne; i++) begin
            c   = (32'(i + 1) * 32'h9E3779B9) & m;
            acc = c ^ ((i % 2 == 0) ? k0 : k1) ^ acc;
            if (i < rn) p[i] = acc;
            else s[(i - rn) / 4][(i - rn) % 4] = acc;
        end
        l = (blk >> hw) & m;
        r = blk & m;
        for (int q = 0; q < rn; q++) begin
            rr = dec ? rn - 1 - q : q;
            x  = dec ? r : l;
            f  = 0;
            for (int j = 0; j < hw / 2; j++) begin
                f = f ^ s[j][(x >> (2 * j)) & 32'h3];
            end
            if (!dec) begin
                t = r ^ f ^ p[rr];
                r = l;
                l = t;
            end else begin
                t = l ^ f ^ p[rr];
                l = r;
                r = t;
            end
        end
        return (l << hw) | r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: at most one block in flight per instance.
    logic [31:0] kmod [3];
    logic [31:0] expv [3];
    bit          pend [3];
    bit          seen [3];
    int          hse [3];

    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                pend[d] = 1'b0;
                seen[d] = 1'b0;
            end else begin
                if (out_v[d]) begin
                    if (!pend[d]) begin
                        check($sformatf("spurious_out_valid%0d", d),
                              {31'b0, out_v[d]}, 32'h0);
                    end else begin
                        check($sformatf("out_data%0d", d), od[d], expv[d]);
                        if (!seen[d]) begin
                            seen[d] = 1'b1;
                            check($sformatf("latency%0d", d),
                                  cyc - hse[d], rn_of(d));
                        end
                        if (orr[d]) pend[d] = 1'b0;
                    end
                end else if (pend[d] && !seen[d]
                             && cyc - hse[d] > rn_of(d)) begin
                    check($sformatf("out_valid_late%0d", d), 0, 1);
                    pend[d] = 1'b0;
                end
                if (iv[d] && in_rdy[d] && !kv[d]) begin
                    pend[d] = 1'b1;
                    seen[d] = 1'b0;
                    hse[d]  = cyc + 1;
                    expv[d] = model(hw_of(d), rn_of(d), kmod[d],
                                    din[d], dec_s[d]);
                end
                if (kv[d] && key_rdy[d]) kmod[d] = key_s[d];
            end
        end
    end

    task automatic load_key(input int d, input logic [31:0] k,
                            output int nb);
        int n;
        @(posedge clock); #1;
        key_s[d] = k;
        kv[d] = 1'b1;
        n = 0;
        while (!key_rdy[d] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        kv[d] = 1'b0;
        nb = 0;
        krbad = 0;
        while (busy[d] && nb < 200) begin
            if (key_rdy[d]) krbad++;
            @(posedge clock); #1;
            nb++;
        end
    endtask

    task automatic take_out(input int d, input int hold,
                            output logic [31:0] y);
        int n, bad;
        n = 0;
        while (!out_v[d] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) check("wait_out_valid", 0, 1);
        bad = 0;
        repeat (hold) begin
            if (in_rdy[d] || !out_v[d]) bad++;
            @(posedge clock); #1;
        end
        if (hold > 0) check("backpressure_hold", bad, 0);
        y = od[d];
        orr[d] = 1'b1;
        @(posedge clock); #1;
        orr[d] = 1'b0;
        if (hold > 0) check("ready_after_release", {31'b0, in_rdy[d]}, 1);
    endtask

    task automatic run_block(input int d, input logic [31:0] x,
                             input bit dec, input int hold,
                             output logic [31:0] y);
        int n;
        @(posedge clock); #1;
        din[d] = x;
        dec_s[d] = dec;
        iv[d] = 1'b1;
        orr[d] = 1'b0;
        n = 0;
        while (!in_rdy[d] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) check("wait_in_ready", 0, 1);
        @(posedge clock); #1;
        iv[d] = 1'b0;
        take_out(d, hold, y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, n;
        logic [31:0] y, y2, k, x;
        kv = '0;
        dec_s = '0;
        iv = '0;
        orr = '0;
        for (int d = 0; d < 3; d++) begin
            key_s[d] = '0;
            din[d] = '0;
            kmod[d] = '0;
        end

        // Hand-derived HALF_W=4, ROUNDS=1, key 0 results.
        check("model_pin_00", model(4, 1, 32'h0, 32'h00, 1'b0), 32'hD0);
        check("model_pin_5a", model(4, 1, 32'h0, 32'h5A, 1'b0), 32'h35);

        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_key_ready%0d", d), {31'b0, key_rdy[d]}, 1);
            check($sformatf("rst_in_ready%0d", d), {31'b0, in_rdy[d]}, 0);
            check($sformatf("rst_out_valid%0d", d), {31'b0, out_v[d]}, 0);
            check($sformatf("rst_busy%0d", d), {31'b0, busy[d]}, 0);
            check($sformatf("rst_out_data%0d", d), od[d], 0);
        end
        reset_n = 1'b1;

        load_key(0, 32'hBEEF, nb);
        check("keyexp_busy_cycles", nb, 24);
        check("key_ready_low_in_keyexp", krbad, 0);
        check("in_ready_after_keyexp", {31'b0, in_rdy[0]}, 1);

        run_block(0, 32'h1234, 1'b0, 0, y);
        check("enc_1234", y, model(8, 8, 32'hBEEF, 32'h1234, 1'b0));
        run_block(0, y, 1'b1, 0, y2);
        check("dec_roundtrip_1234", y2, 32'h1234);

        run_block(0, 32'hA55A, 1'b0, 10, y);

        // Key and block offered together: key wins.
        @(posedge clock); #1;
        key_s[0] = 32'h0F1E;
        kv[0] = 1'b1;
        din[0] = 32'hC3C3;
        dec_s[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clock); #1;
        kv[0] = 1'b0;
        check("in_ready_drop_on_rekey", {31'b0, in_rdy[0]}, 0);
        n = 0;
        while (!in_rdy[0] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("rekey_block_wait", n, 24);
        @(posedge clock); #1;
        iv[0] = 1'b0;
        take_out(0, 0, y);
        check("rekey_block", y, model(8, 8, 32'h0F1E, 32'hC3C3, 1'b0));

        // Asynchronous reset during round 4.
        @(posedge clock); #1;
        din[0] = 32'h7777;
        dec_s[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clock); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        check("busy_before_reset", {31'b0, busy[0]}, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, out_v[0]}, 0);
        check("async_rst_key_ready", {31'b0, key_rdy[0]}, 1);
        check("async_rst_busy", {31'b0, busy[0]}, 0);
        check("async_rst_out_data", od[0], 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        iv[0] = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("no_accept_without_key", {31'b0, in_rdy[0]}, 0);
        check("no_busy_without_key", {31'b0, busy[0]}, 0);
        iv[0] = 1'b0;

        for (int it = 0; it < 10; it++) begin
            k = $urandom & bw_mask(0);
            x = $urandom & bw_mask(0);
            load_key(0, k, nb);
            run_block(0, x, 1'b0, 0, y);
            run_block(0, y, 1'b1, 0, y2);
            check("rand0_roundtrip", y2, x);
        end

        for (int it = 0; it < 100; it++) begin
            for (int d = 1; d < 3; d++) begin
                k = $urandom & bw_mask(d);
                x = $urandom & bw_mask(d);
                load_key(d, k, nb);
                check($sformatf("sweep_keyexp%0d", d), nb,
                      rn_of(d) + 2 * hw_of(d));
                run_block(d, x, 1'b0, 0, y);
                check($sformatf("sweep_enc%0d", d), y,
                      model(hw_of(d), rn_of(d), k, x, 1'b0));
                run_block(d, y, 1'b1, 0, y2);
                check($sformatf("sweep_roundtrip%0d", d), y2, x);
            end
        end

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
